// File: rtl/game_pkg.sv
// game_pkg: state encodings and default parameters for the runner-game controller
package game_pkg;
  localparam int SPEED_W = 3;
  localparam int LIVES_DEF = 3;
  localparam int FRAMES_PER_POINT_DEF = 6;
  localparam int SCORE_MAX_DEF = 9999;
  localparam int SCORE_W_DEF = 14;
  localparam int SPEEDUP_PTS_DEF = 100;
  localparam int MAX_SPEED_DEF = 7;
  localparam int GRACE_FRAMES_DEF = 60;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_RUN   = 3'b001,
    ST_HIT   = 3'b010,
    ST_PAUSE = 3'b011,
    ST_DEAD  = 3'b100
  } state_t;
endpackage

// File: rtl/game_ctrl_fsm_if.sv
// game_ctrl_fsm_if: control inputs and status outputs between the game controller and its neighbours
interface game_ctrl_fsm_if
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic start;
  logic collided;
  logic frame_tick;
  logic pause;
  logic [2:0] state;
  logic run;
  logic dead;
  logic hit;
  logic [2:0] lives_left;
  logic [SCORE_W-1:0] score;
  logic [SPEED_W-1:0] speed;
  modport master (
    output start, collided, frame_tick, pause,
    input  state, run, dead, hit, lives_left, score, speed
  );
  modport slave (
    input  start, collided, frame_tick, pause,
    output state, run, dead, hit, lives_left, score, speed
  );
endinterface

// File: rtl/game_score_counter.sv
// game_score_counter: frame prescaler, saturating score and saturating speed level
module game_score_counter
  import game_pkg::*;
#(
  parameter int FRAMES_PER_POINT = FRAMES_PER_POINT_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int SPEEDUP_PTS = SPEEDUP_PTS_DEF,
  parameter int MAX_SPEED = MAX_SPEED_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic frame_tick,
  output logic [SCORE_W-1:0] score,
  output logic [SPEED_W-1:0] speed
);
  localparam int FW = $clog2(FRAMES_PER_POINT + 1);
  localparam int PW = $clog2(SPEEDUP_PTS + 1);
  logic [FW-1:0] frame_cnt;
  logic [PW-1:0] pts_cnt;
  logic step, wrap, inc, lvl;
  assign step = enable && frame_tick;
  assign wrap = step && frame_cnt == FW'(FRAMES_PER_POINT - 1);
  assign inc = wrap && score != SCORE_W'(SCORE_MAX);
  assign lvl = inc && pts_cnt == PW'(SPEEDUP_PTS - 1);
  // pts_cnt tracks score modulo SPEEDUP_PTS so a level-up needs no divider
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      frame_cnt <= '0;
      pts_cnt <= '0;
      score <= '0;
      speed <= SPEED_W'(1);
    end else if (step) begin
      frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
      if (inc) score <= score + 1'b1;
      if (inc) pts_cnt <= lvl ? '0 : pts_cnt + 1'b1;
      if (lvl && speed != SPEED_W'(MAX_SPEED)) speed <= speed + 1'b1;
    end
  end
endmodule

// File: rtl/game_ctrl_fsm.sv
// game_ctrl_fsm: runner-game state, lives and hit-grace control; GAME_PAUSE_EN adds a pause state
module game_ctrl_fsm
  import game_pkg::*;
#(
  parameter int LIVES = LIVES_DEF,
  parameter int FRAMES_PER_POINT = FRAMES_PER_POINT_DEF,
  parameter int SCORE_MAX = SCORE_MAX_DEF,
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int SPEEDUP_PTS = SPEEDUP_PTS_DEF,
  parameter int MAX_SPEED = MAX_SPEED_DEF,
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEF
) (
  input logic clk,
  input logic reset,
  game_ctrl_fsm_if.slave io
);
  localparam int GW = $clog2(GRACE_FRAMES + 1);
  state_t state, state_n, ret, ret_n;
  logic [2:0] lives, lives_n;
  logic [GW-1:0] grace, grace_n;
  logic clear, enable, pausing, run, dead, hit;
`ifdef GAME_PAUSE_EN
  assign pausing = io.pause;
`else
  logic unused_pause;
  assign unused_pause = io.pause;
  assign pausing = 1'b0;
`endif
  game_score_counter #(
    .FRAMES_PER_POINT(FRAMES_PER_POINT),
    .SCORE_MAX(SCORE_MAX),
    .SCORE_W(SCORE_W),
    .SPEEDUP_PTS(SPEEDUP_PTS),
    .MAX_SPEED(MAX_SPEED)
  ) u_score (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .enable(enable),
    .frame_tick(io.frame_tick),
    .score(io.score),
    .speed(io.speed)
  );
  // next state, lives and grace; start low beats everything, then collided, pause, frame_tick
  always_comb begin
    state_n = state;
    ret_n = ret;
    lives_n = lives;
    grace_n = grace;
    clear = 1'b0;
    enable = 1'b0;
    if (!io.start) begin
      state_n = ST_IDLE;
      lives_n = 3'(LIVES);
      clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_RUN;
          lives_n = 3'(LIVES);
          grace_n = '0;
          clear = 1'b1;
        end
        ST_RUN: begin
          enable = !io.collided && !pausing;
          if (io.collided) begin
            lives_n = lives - 3'd1;
            state_n = lives == 3'd1 ? ST_DEAD : ST_HIT;
            grace_n = '0;
          end else if (pausing) begin
            ret_n = ST_RUN;
            state_n = ST_PAUSE;
          end
        end
        ST_HIT: begin
          enable = !pausing;
          if (pausing) begin
            ret_n = ST_HIT;
            state_n = ST_PAUSE;
          end else if (io.frame_tick) begin
            state_n = grace == GW'(GRACE_FRAMES - 1) ? ST_RUN : ST_HIT;
            grace_n = grace + 1'b1;
          end
        end
        ST_PAUSE: state_n = pausing ? ST_PAUSE : ret;
        default: ;
      endcase
    end
  end
  // state register plus flags registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ret <= ST_RUN;
      lives <= 3'(LIVES);
      grace <= '0;
      run <= 1'b0;
      dead <= 1'b0;
      hit <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      lives <= lives_n;
      grace <= grace_n;
      run <= state_n == ST_RUN || state_n == ST_HIT;
      dead <= state_n == ST_DEAD;
      hit <= state_n == ST_HIT;
    end
  end
  assign io.state = state;
  assign io.run = run;
  assign io.dead = dead;
  assign io.hit = hit;
  assign io.lives_left = lives;
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// tb_game_ctrl_fsm: randomized scoreboard bench for game_ctrl_fsm (honours GAME_PAUSE_EN)
module tb_game_ctrl_fsm;
  localparam int LIVES = 3;
  localparam int FPP = 6;
  localparam int SMAX = 850;
  localparam int SPD = 100;
  localparam int VMAX = 7;
  localparam int GRACE = 60;
  localparam int IDLE = 0, RUN = 1, HIT = 2, PAUSE = 3, DEAD = 4;
`ifdef GAME_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  typedef struct packed {
    logic [2:0] st;
    logic run;
    logic dead;
    logic hit;
    logic [2:0] lives;
    logic [13:0] score;
    logic [2:0] speed;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  game_ctrl_fsm_if #(.SCORE_W(14)) io ();
  game_ctrl_fsm #(
    .LIVES(LIVES),
    .FRAMES_PER_POINT(FPP),
    .SCORE_MAX(SMAX),
    .SCORE_W(14),
    .SPEEDUP_PTS(SPD),
    .MAX_SPEED(VMAX),
    .GRACE_FRAMES(GRACE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(io)
  );

  obs_t q[$];
  obs_t m_exp, m_got;
  int checks = 0;
  int errors = 0;
  int m_mode = IDLE, m_ret = RUN, m_lives = LIVES, m_score = 0, m_frames = 0, m_left = 0;
  bit pz = 1'b0;

  function automatic int exp_speed(int sc);
    int v = 1 + sc / SPD;
    return v > VMAX ? VMAX : v;
  endfunction

  task automatic m_frame();
    m_frames++;
    if (m_frames % FPP == 0 && m_score < SMAX) m_score++;
  endtask

  task automatic m_restart();
    m_score = 0;
    m_frames = 0;
    m_lives = LIVES;
  endtask

  task automatic model_step(input bit r, s, c, f, p);
    bit pp = PEN && p;
    obs_t e;
    if (r || !s) begin
      m_mode = IDLE;
      m_restart();
    end else if (m_mode == IDLE) begin
      m_mode = RUN;
      m_restart();
    end else if (m_mode == RUN) begin
      if (c) begin
        m_lives--;
        m_mode = m_lives == 0 ? DEAD : HIT;
        m_left = GRACE;
      end else if (pp) begin
        m_ret = RUN;
        m_mode = PAUSE;
      end else if (f) m_frame();
    end else if (m_mode == HIT) begin
      if (pp) begin
        m_ret = HIT;
        m_mode = PAUSE;
      end else if (f) begin
        m_frame();
        m_left--;
        if (m_left == 0) m_mode = RUN;
      end
    end else if (m_mode == PAUSE) begin
      if (!pp) m_mode = m_ret;
    end
    e.st = 3'(m_mode);
    e.run = m_mode == RUN || m_mode == HIT;
    e.dead = m_mode == DEAD;
    e.hit = m_mode == HIT;
    e.lives = 3'(m_lives);
    e.score = 14'(m_score);
    e.speed = 3'(exp_speed(m_score));
    q.push_back(e);
  endtask

  task automatic apply(input bit r, s, c, f, p);
    @(negedge clk);
    reset = r;
    io.start = s;
    io.collided = c;
    io.frame_tick = f;
    io.pause = p;
    model_step(r, s, c, f, p);
  endtask

  task automatic run_phase(input int n, p_ft, p_col, p_pause, p_stop);
    bit s, c, f, r;
    pz = 1'b0;
    for (int i = 0; i < n; i++) begin
      r = p_stop > 0 && $urandom_range(0, 3999) == 0;
      s = $urandom_range(0, 999) >= p_stop;
      if (m_mode == DEAD && $urandom_range(0, 15) == 0) s = 1'b0;
      c = $urandom_range(0, 99) < p_col;
      f = $urandom_range(0, 99) < p_ft;
      if ($urandom_range(0, 99) < p_pause) pz = !pz;
      apply(r, s, c, f, pz);
    end
  endtask

  // monitor: one expected observation per clock, compared just after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_exp = q.pop_front();
      m_got = {io.state, io.run, io.dead, io.hit, io.lives_left, io.score, io.speed};
      checks++;
      if (m_got !== m_exp)
        begin
          errors++;
          $display("FAIL outputs t=%0t got st=%0d run=%0b dead=%0b hit=%0b lives=%0d score=%0d speed=%0d exp st=%0d run=%0b dead=%0b hit=%0b lives=%0d score=%0d speed=%0d",
            $time, m_got.st, m_got.run, m_got.dead, m_got.hit, m_got.lives, m_got.score, m_got.speed,
            m_exp.st, m_exp.run, m_exp.dead, m_exp.hit, m_exp.lives, m_exp.score, m_exp.speed);
        end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    io.start = 1'b0;
    io.collided = 1'b0;
    io.frame_tick = 1'b0;
    io.pause = 1'b0;
    apply(1, 1, 1, 1, 1);
    apply(1, 1, 0, 1, 0);
    run_phase(1500, 50, 0, 0, 0);
    run_phase(8000, 50, 1, 2, 1);
    apply(0, 0, 0, 0, 0);
    run_phase(700, 60, 100, 0, 0);
    apply(0, 0, 0, 0, 0);
    run_phase(5300, 100, 0, 0, 0);
    run_phase(400, 50, 5, 3, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
